// File: rtl/maxpool_stage.sv
// maxpool_stage: streaming 2x2 max pooling over a WxW conv feature map
// delivered in raster order, with optional ReLU on the pooled result.
module maxpool_stage #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_SIZE     = 3,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  running_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int W  = N - K_SIZE + 1;
    localparam int PW = W / 2;
    // Buffer is rounded up to a power of two so the index is exactly AW bits.
    localparam int AW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [15:0] COL_LAST = 16'(W - 1);
    localparam logic [15:0] CNT_LAST = 16'(W * W - 1);
    localparam logic [15:0] PW2      = 16'(2 * PW);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                state, state_n;
    logic [15:0]           col, row, cnt;
    logic [DATA_WIDTH-1:0] h;
    logic [DATA_WIDTH-1:0] line_buf [0:(1<<AW)-1];
    logic [AW-1:0]         bidx;
    logic [DATA_WIDTH-1:0] hmax, bval, pooled, result;
    logic                  accept, abort, last;

    // Acceptance, abort and end-of-frame qualifiers.
    always_comb begin
        accept = valid_i && running_i && (state == ACTIVE || state == IDLE);
        abort  = (state == ACTIVE) && !running_i;
        last   = accept && (cnt == CNT_LAST);
    end

    // Horizontal max, vertical max against the line buffer, optional ReLU.
    always_comb begin
        bidx   = col[AW:1];
        hmax   = ($signed(data_i) > $signed(h)) ? data_i : h;
        bval   = line_buf[bidx];
        pooled = ($signed(hmax) > $signed(bval)) ? hmax : bval;
        result = (RELU_EN != 0 && pooled[DATA_WIDTH-1]) ? '0 : pooled;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; done_o is a Moore output of the DONE state.
    always_comb begin
        state_n = state;
        done_o  = 1'b0;
        case (state)
            IDLE:    if (running_i) state_n = last ? DONE : ACTIVE;
            ACTIVE: begin
                if (!running_i) state_n = IDLE;
                else if (last)  state_n = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Position counters, horizontal register and registered pooled output.
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            cnt     <= '0;
            h       <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= abort;
            if (accept) begin
                if (!col[0] && col < PW2) h <= data_i;
                // Odd col/row are always inside the pooled region.
                if (col[0] && row[0]) begin
                    data_o  <= result;
                    valid_o <= 1'b1;
                end
                cnt <= cnt + 16'd1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
            // Frame ended or abandoned: next frame starts from a clean origin.
            if (abort || last) begin
                col <= '0;
                row <= '0;
                cnt <= '0;
                h   <= '0;
            end
        end
    end

    // Line buffer holds the even-row horizontal maxima; no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && accept && col[0] && !row[0] && row < PW2)
            line_buf[bidx] <= hmax;
    end
endmodule
